// File: rtl/serial_add_sub_mux.sv
// Bit-serial adder/subtractor: operands shift out LSB first through a mux-based
// full add/sub cell with a carry/borrow flop; results register on the last bit.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one operand bit per cycle, LSB first
// S_DONE | single-cycle done pulse; start accepted here too
module serial_add_sub_mux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             mode_q;
    logic             a_msb, b_msb;

    logic             ai, bi, s_bit, c_nxt, ovf_nxt;
    logic [WIDTH-1:0] res_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    last_bit  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Cell: XOR chain for the sum/difference bit, carry/borrow muxed on ai.
    assign ai      = a_sh[0];
    assign bi      = b_sh[0];
    assign s_bit   = ai ^ bi ^ cy;
    assign c_nxt   = mode_q ? (ai ? (bi & cy) : (bi | cy))
                            : (ai ? (bi | cy) : (bi & cy));
    assign res_nxt = (res_sh >> 1) | {s_bit, {(WIDTH-1){1'b0}}};
    assign ovf_nxt = mode_q ? ((a_msb != b_msb) && (s_bit != a_msb))
                            : ((a_msb == b_msb) && (s_bit != a_msb));

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            cnt       <= '0;
            cy        <= 1'b0;
            mode_q    <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_q <= mode;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            cy     <= 1'b0;
            cnt    <= '0;
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt;
            cy     <= c_nxt;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                result    <= res_nxt;
                carry_out <= c_nxt;
                overflow  <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub_mux.sv
// Bench for serial_add_sub_mux: directed corner cases plus random ops checked
// against a plain-arithmetic model.
module tb_serial_add_sub_mux;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result;
    logic         carry_out, overflow;

    int checks = 0;
    int errors = 0;

    serial_add_sub_mux #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {carry, overflow, result}
    function automatic logic [W+1:0] model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
        int ux, uy, sx, sy, u, s;
        logic [W-1:0] r;
        logic c, o;
        ux = int'(x);
        uy = int'(y);
        sx = $signed(x);
        sy = $signed(y);
        if (!m) begin
            u = ux + uy;
            s = sx + sy;
            c = (u > 255);
        end else begin
            u = ux - uy;
            s = sx - sy;
            c = (ux < uy);
        end
        r = u[W-1:0];
        o = (s > 127) || (s < -128);
        return {c, o, r};
    endfunction

    // Launch one op and watch a bounded window; lat = -1 if done never appears.
    task automatic do_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int ndone,
                         output logic [W-1:0] r, output logic c, output logic o);
        lat   = -1;
        ndone = 0;
        r     = '0;
        c     = 1'b0;
        o     = 1'b0;
        mode  = m;
        a     = x;
        b     = y;
        start = 1'b1;
        for (int i = 1; i <= W + 3; i++) begin
            step();
            if (i == 1) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = i;
                    r   = result;
                    c   = carry_out;
                    o   = overflow;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        step();
        step();
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 8'h00)   begin errors++; $display("FAIL reset_result got %h want 00", result); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", carry_out); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_vectors();
        logic [W+1:0] exp;
        logic [W-1:0] r;
        logic c, o;
        int lat, nd;
        logic         vm [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] va [4] = '{8'hFF, 8'h05, 8'h7F, 8'h80};
        logic [W-1:0] vb [4] = '{8'h01, 8'h07, 8'h01, 8'h01};
        logic [W+1:0] vx [4] = '{{1'b1, 1'b0, 8'h00}, {1'b1, 1'b0, 8'hFE},
                                  {1'b0, 1'b1, 8'h80}, {1'b0, 1'b1, 8'h7F}};
        for (int k = 0; k < 4; k++) begin
            exp = vx[k];
            do_op(vm[k], va[k], vb[k], lat, nd, r, c, o);
            checks++; if (lat !== W + 1)         begin errors++; $display("FAIL vec%0d_latency got %0d want %0d", k, lat, W + 1); end
            checks++; if (nd !== 1)              begin errors++; $display("FAIL vec%0d_done_count got %0d want 1", k, nd); end
            checks++; if (r !== exp[W-1:0])      begin errors++; $display("FAIL vec%0d_result got %h want %h", k, r, exp[W-1:0]); end
            checks++; if (c !== exp[W+1])        begin errors++; $display("FAIL vec%0d_carry got %b want %b", k, c, exp[W+1]); end
            checks++; if (o !== exp[W])          begin errors++; $display("FAIL vec%0d_overflow got %b want %b", k, o, exp[W]); end
            checks++; if (result !== exp[W-1:0]) begin errors++; $display("FAIL vec%0d_result_hold got %h want %h", k, result, exp[W-1:0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] e1, e2;
        int seen;
        e1 = model(1'b0, 8'h3C, 8'h21);
        e2 = model(1'b1, 8'h10, 8'h4A);
        mode = 1'b0; a = 8'h3C; b = 8'h21; start = 1'b1;
        step();                                    // T+1
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
        step(); step();                            // T+3
        mode = 1'b1; a = 8'hAA; b = 8'h55; start = 1'b1;
        step();                                    // T+4
        start = 1'b0;
        seen = 0;
        for (int i = 5; i < W + 1; i++) begin
            step();
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL b2b_early_done got %0d want 0", seen); end
        step();                                    // T+9
        checks++; if (done !== 1'b1)           begin errors++; $display("FAIL b2b_first_done got %b want 1", done); end
        checks++; if (result !== e1[W-1:0])    begin errors++; $display("FAIL b2b_first_result got %h want %h", result, e1[W-1:0]); end
        checks++; if (carry_out !== e1[W+1])   begin errors++; $display("FAIL b2b_first_carry got %b want %b", carry_out, e1[W+1]); end
        mode = 1'b1; a = 8'h10; b = 8'h4A; start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_relaunch got done=%b busy=%b want done=0 busy=1", done, busy); end
        for (int i = 2; i < W + 1; i++) step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_second_early got %b want 0", done); end
        step();
        checks++; if (done !== 1'b1)         begin errors++; $display("FAIL b2b_second_done got %b want 1", done); end
        checks++; if (result !== e2[W-1:0])  begin errors++; $display("FAIL b2b_second_result got %h want %h", result, e2[W-1:0]); end
        checks++; if (carry_out !== e2[W+1]) begin errors++; $display("FAIL b2b_second_carry got %b want %b", carry_out, e2[W+1]); end
        checks++; if (overflow !== e2[W])    begin errors++; $display("FAIL b2b_second_overflow got %b want %b", overflow, e2[W]); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_single_pulse got %b want 0", done); end
    endtask

    task automatic test_abort();
        logic [W-1:0] r;
        logic c, o;
        int lat, nd, seen;
        checks++; if (result === 8'h00) begin errors++; $display("FAIL abort_precondition got result %h want nonzero", result); end
        mode = 1'b0; a = 8'hC3; b = 8'h9A; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();                    // T+4
        rst = 1'b1;
        step();                                    // T+5
        rst = 1'b0;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (result !== 8'h00)   begin errors++; $display("FAIL abort_result got %h want 00", result); end
        checks++; if (carry_out !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL abort_flags got c=%b o=%b want 0 0", carry_out, overflow); end
        seen = (done === 1'b1) ? 1 : 0;
        for (int i = 0; i < W + 4; i++) begin
            step();
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", seen); end

        rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h02; mode = 1'b0;
        step();
        rst = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy got %b want 0", busy); end
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            step();
            if (done || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_start_activity got %0d want 0", seen); end

        do_op(1'b0, 8'h12, 8'h34, lat, nd, r, c, o);
        checks++; if (lat !== W + 1 || nd !== 1) begin errors++; $display("FAIL post_abort_timing got lat=%0d n=%0d want %0d 1", lat, nd, W + 1); end
        checks++; if (r !== 8'h46 || c !== 1'b0 || o !== 1'b0) begin errors++; $display("FAIL post_abort_result got %h c=%b o=%b want 46 0 0", r, c, o); end
    endtask

    task automatic test_random();
        logic [W+1:0] exp;
        logic [W-1:0] x, y, r;
        logic m, c, o;
        int lat, nd;
        for (int k = 0; k < 1000; k++) begin
            m = 1'($urandom_range(0, 1));
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            exp = model(m, x, y);
            do_op(m, x, y, lat, nd, r, c, o);
            checks++;
            if (lat !== W + 1 || nd !== 1 || r !== exp[W-1:0] || c !== exp[W+1] || o !== exp[W]) begin
                errors++;
                $display("FAIL rand%0d m=%b a=%h b=%h got lat=%0d n=%0d r=%h c=%b o=%b want lat=%0d n=1 r=%h c=%b o=%b",
                         k, m, x, y, lat, nd, r, c, o, W + 1, exp[W-1:0], exp[W+1], exp[W]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
